// File: rtl/tristate_bus_pkg.sv
// Shared types and constants for the tri-state bus controller.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DRIVE = 2'd2,
    POST  = 2'd3
  } state_t;

  localparam int TURN_CNT_W   = 4;
  localparam int TURN_CYC_MIN = 1;
  localparam int TURN_CYC_MAX = 15;

endpackage

// File: rtl/tristate_turn_cnt.sv
// Loadable turnaround down-counter; done flags the final cycle of a gap.
module tristate_turn_cnt
  import tristate_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TURN_CNT_W-1:0] load_val,
  output logic                  done
);

  logic [TURN_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TURN_CNT_W'(1);
    end
  end

  assign done = (cnt == TURN_CNT_W'(1));

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Half-duplex tri-state bus controller with turnaround gaps and read-back sampling.
// Optional sticky contention flag ERR is built when BUS_CONTENTION_CHK_EN is defined.
module tristate_bus_ctrl
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_VALID,
  output logic             TX_READY,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LAST,
  input  logic             RX_REQ,
  output logic             RX_VALID,
  output logic [WIDTH-1:0] RX_DATA,
  input  logic [WIDTH-1:0] BUS_IN,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             BUS_EN,
`ifdef BUS_CONTENTION_CHK_EN
  output logic             ERR,
`endif
  output logic             BUSY
);

  if (TURN_CYC < TURN_CYC_MIN || TURN_CYC > TURN_CYC_MAX) begin : g_bad_turn_cyc
    $error("tristate_bus_ctrl: TURN_CYC out of range 1..15");
  end

  localparam logic [TURN_CNT_W-1:0] TURN_LD = TURN_CNT_W'(TURN_CYC);

  state_t state, state_nxt;
  logic   last_q;
  logic   rst_q;
  logic   hs;
  logic   cnt_load;
  logic   cnt_done;
  logic   rx_take;

  // rst_q keeps TX_READY low for the whole reset pulse without an RST-to-output path
  always_comb begin
    TX_READY = !rst_q && ((state == IDLE) || ((state == DRIVE) && !last_q));
    hs       = TX_VALID && TX_READY;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    rx_take   = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = PRE;
          cnt_load  = 1'b1;
        end else if (RX_REQ) begin
          rx_take = 1'b1;
        end
      end
      PRE: begin
        if (cnt_done) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (last_q) begin
          state_nxt = POST;
          cnt_load  = 1'b1;
        end
      end
      POST: begin
        if (cnt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  tristate_turn_cnt u_turn_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (TURN_LD),
    .done     (cnt_done)
  );

  // Outputs are registered from next-state so BUS_EN lines up with the DRIVE state
  always_ff @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      state    <= IDLE;
      last_q   <= 1'b0;
      BUS_OUT  <= '0;
      BUS_EN   <= 1'b0;
      BUSY     <= 1'b0;
      RX_VALID <= 1'b0;
      RX_DATA  <= '0;
    end else begin
      state    <= state_nxt;
      BUS_EN   <= (state_nxt == DRIVE);
      BUSY     <= (state_nxt != IDLE);
      RX_VALID <= rx_take;
      if (hs) begin
        BUS_OUT <= TX_DATA;
        last_q  <= TX_LAST;
      end
      if (rx_take) RX_DATA <= BUS_IN;
    end
  end

`ifdef BUS_CONTENTION_CHK_EN
  logic en_p1;
  logic ld_p1;

  // Compare only once the enable has settled and the driven word has been stable a cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR   <= 1'b0;
      en_p1 <= 1'b0;
      ld_p1 <= 1'b0;
    end else begin
      en_p1 <= BUS_EN;
      ld_p1 <= hs;
      if (BUS_EN && en_p1 && !ld_p1 && (BUS_IN != BUS_OUT)) ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/tristate_bus_ctrl.md
# tristate_bus_ctrl

Half-duplex controller that sits directly upstream of a row of enable-high tri-state pad buffers and generates each buffer's data input and common enable. It accepts write bursts over a valid/ready handshake and drives them onto the shared bus. It inserts programmable turnaround gaps so the enable never asserts while data is changing, and never overlaps another driver. With the bus released, it also samples the read-back bus on request.

## Interface
- WIDTH, 8: bus width; one tri-state buffer per bit.
- TURN_CYC, 2: turnaround cycles before enable-on and after enable-off; legal range 1..15.

- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- TX_VALID  input  1  write word offered.
- TX_READY  output  1  write word accepted when TX_VALID && TX_READY at the clock edge.
- TX_DATA  input  WIDTH  write word.
- TX_LAST  input  1  marks the final word of a burst.
- RX_REQ  input  1  request one sample of the bus.
- RX_VALID  output  1  one-cycle pulse; RX_DATA is valid.
- RX_DATA  output  WIDTH  sampled bus value.
- BUS_IN  input  WIDTH  read-back from the buffer inout pins.
- BUS_OUT  output  WIDTH  to the buffer data inputs.
- BUS_EN  output  1  to the buffer enables; high drives the bus.
- BUSY  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, PRE, DRIVE, POST.
- Reset (RST=1 at an edge) applies regardless of state:
  - next state IDLE;
  - BUS_EN=0, BUS_OUT=0, TX_READY=0 during reset, RX_VALID=0, RX_DATA=0, BUSY=0;
  - turnaround counter=0, last-flag=0.
- IDLE:
  - BUS_EN=0; TX_READY=1.
  - On a TX handshake: load BUS_OUT←TX_DATA and last-flag←TX_LAST, set counter←TURN_CYC, go to PRE.
  - Else if RX_REQ=1: register RX_DATA←BUS_IN and pulse RX_VALID next cycle; stay in IDLE.
  - If TX handshake and RX_REQ coincide, TX wins and RX_REQ is ignored; the requester must hold RX_REQ.
- PRE:
  - BUS_EN=0, TX_READY=0, BUS_OUT stable.
  - Counter decrements each cycle; at 1, go to DRIVE.
- DRIVE:
  - BUS_EN=1.
  - TX_READY = !last-flag.
  - On a handshake: BUS_OUT←TX_DATA, last-flag←TX_LAST.
  - With no TX_VALID, the current word stays driven (stall).
  - When last-flag=1, the current word is driven for exactly one cycle, then counter←TURN_CYC and the state goes to POST.
- POST:
  - BUS_EN=0; TX_READY=0; RX_REQ ignored.
  - BUS_OUT holds its last value.
  - Counter decrements; at 1, go to IDLE.
- A single-word burst (TX_LAST on the first word) gives PRE(TURN_CYC) → DRIVE(1) → POST(TURN_CYC).
- A burst never ends without TX_LAST; holding TX_VALID low simply extends DRIVE.

## Timing
- All outputs are registered; no combinational input-to-output path except TX_READY, which is decoded from state and last-flag only.
- First word: handshake at edge N gives BUS_EN=1 from edge N+TURN_CYC+1.
- Back-to-back words in DRIVE change BUS_OUT every cycle while BUS_EN stays 1.
- Last word:
  - BUS_EN falls one cycle after the last word appears.
  - The next TX_READY in IDLE comes TURN_CYC cycles after BUS_EN falls.
- RX latency: RX_REQ sampled at edge N gives RX_VALID=1 and RX_DATA during cycle N+1, for one cycle.
- BUS_OUT never changes in the same cycle that BUS_EN rises or falls.

## Configuration
- BUS_CONTENTION_CHK_EN defined:
  - Adds output ERR (1 bit, reset 0, sticky until RST).
  - On any edge where BUS_EN was 1 in both the current and previous cycle and BUS_IN != BUS_OUT, ERR←1.
  - BUS_IN is compared only in cycles where BUS_OUT did not change in the previous cycle.
- Not defined: the ERR port and the compare logic are absent, and all other behaviour is identical.

## Structure
- Package tristate_bus_pkg holds:
  - the state enum (IDLE, PRE, DRIVE, POST);
  - TURN_CNT_W=4;
  - the localparam bounds for TURN_CYC.
- The top level checks TURN_CYC against its bounds at elaboration.
- One natural sub-module, tristate_turn_cnt: a loadable down-counter with a "done at 1" flag, shared by PRE and POST.
- The FSM, data register and RX sampler live in the top level.

## Test plan
- Reset: apply RST for 2 cycles mid-DRIVE with BUS_EN=1 → BUS_EN=0, BUSY=0, TX_READY=0 on the next edge; TX_READY=1 after RST falls.
- Single word: WIDTH=8, TURN_CYC=2, send 0xA5 with TX_LAST at edge 10 → BUS_EN=1 only in cycle 13 with BUS_OUT=0xA5; BUS_EN=0 in cycles 14–15; TX_READY=1 at 16.
- Burst with stall:
  - Send words 0x01, 0x02, 0x03(LAST), dropping TX_VALID for 3 cycles after 0x02.
  - Required: BUS_OUT=0x02 held for 4 cycles, BUS_EN continuously 1, 0x03 driven for one cycle, then release.
- RX sample: in IDLE with BUS_IN=0x3C, pulse RX_REQ → RX_VALID=1 and RX_DATA=0x3C the next cycle only. RX_REQ raised during POST → no RX_VALID until IDLE.
- Collision: TX_VALID and RX_REQ asserted together in IDLE → TX accepted, no RX_VALID; RX_REQ still high on return to IDLE → sample taken then.
- Contention (BUS_CONTENTION_CHK_EN): force BUS_IN=0x00 while driving 0xFF for 2 cycles → ERR=1 and stays 1 through IDLE until RST. Without the macro, the same stimulus gives unchanged outputs and no ERR port.
